// File: rtl/board_mem_arbiter.sv
// Board memory arbiter: the clear sequence, game writes and VGA reads share one board memory port.
// Define BOARD_ARB_AGE_EN to let a long-waiting VGA request outrank the game controller.
module board_mem_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_req,
  output logic       clear_busy,
  output logic       clear_done,
  input  logic       game_req,
  input  logic [2:0] game_addr,
  input  logic [5:0] game_onoff,
  input  logic [5:0] game_player,
  output logic       game_gnt,
  input  logic       vga_req,
  input  logic [2:0] vga_addr,
  output logic       vga_gnt,
  output logic       vga_valid,
  output logic [2:0] mem_address,
  output logic       onoff_write,
  output logic       player_write,
  output logic [5:0] write_to_onoff,
  output logic [5:0] write_to_player
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] LAST_COL = 3'd6;
  localparam logic [2:0] BAD_COL  = 3'd7;

  state_t     state_q, state_d;
  logic [2:0] col_q, col_d;

  logic [2:0] memAddr_q, memAddr_d;
  logic       onoffWr_q, onoffWr_d;
  logic       playerWr_q, playerWr_d;
  logic [5:0] onoffData_q, onoffData_d;
  logic [5:0] playerData_q, playerData_d;
  logic       gameGnt_q, gameGnt_d;
  logic       vgaGnt_q, vgaGnt_d;
  logic       vgaValid_q, vgaValid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       arbEn;
  logic       gameElig;
  logic       vgaElig;
  logic       vgaFirst;
  logic       grantGame;
  logic       grantVga;

`ifdef BOARD_ARB_AGE_EN
  logic [2:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (!vga_req || vgaGnt_q) begin
      age_d = '0;
    end else if (age_q != 3'd7) begin
      age_d = age_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign vgaFirst = (age_q >= 3'd4);
`else
  assign vgaFirst = 1'b0;
`endif

  // Grants are only decided on edges whose following cycle is plain IDLE.
  // A grant blocks its own requester next cycle, and a game grant also holds VGA
  // off for that gap so a game controller re-requesting straight away keeps priority.
  assign arbEn     = (state_q == DONE) || ((state_q == IDLE) && !clear_req);
  assign gameElig  = game_req && !gameGnt_q;
  assign vgaElig   = vga_req && !vgaGnt_q && !gameGnt_q;
  assign grantVga  = arbEn && vgaElig && (vgaFirst || !gameElig);
  assign grantGame = arbEn && gameElig && !grantVga;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          col_d   = '0;
        end
      end
      CLEAR: begin
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end else begin
          col_d = col_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Port values are computed for the coming cycle so every output is a flop.
  always_comb begin
    memAddr_d    = '0;
    onoffWr_d    = 1'b0;
    playerWr_d   = 1'b0;
    onoffData_d  = '0;
    playerData_d = '0;
    gameGnt_d    = 1'b0;
    vgaGnt_d     = 1'b0;
    vgaValid_d   = vgaGnt_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    case (state_d)
      CLEAR: begin
        memAddr_d  = col_d;
        onoffWr_d  = 1'b1;
        playerWr_d = 1'b1;
        busy_d     = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        if (grantGame) begin
          gameGnt_d    = 1'b1;
          memAddr_d    = game_addr;
          onoffWr_d    = (game_addr != BAD_COL);
          playerWr_d   = (game_addr != BAD_COL);
          onoffData_d  = game_onoff;
          playerData_d = game_player;
        end else if (grantVga) begin
          vgaGnt_d  = 1'b1;
          memAddr_d = vga_addr;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      memAddr_q    <= '0;
      onoffWr_q    <= 1'b0;
      playerWr_q   <= 1'b0;
      onoffData_q  <= '0;
      playerData_q <= '0;
      gameGnt_q    <= 1'b0;
      vgaGnt_q     <= 1'b0;
      vgaValid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      memAddr_q    <= memAddr_d;
      onoffWr_q    <= onoffWr_d;
      playerWr_q   <= playerWr_d;
      onoffData_q  <= onoffData_d;
      playerData_q <= playerData_d;
      gameGnt_q    <= gameGnt_d;
      vgaGnt_q     <= vgaGnt_d;
      vgaValid_q   <= vgaValid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign clear_busy      = busy_q;
  assign clear_done      = done_q;
  assign game_gnt        = gameGnt_q;
  assign vga_gnt         = vgaGnt_q;
  assign vga_valid       = vgaValid_q;
  assign mem_address     = memAddr_q;
  assign onoff_write     = onoffWr_q;
  assign player_write    = playerWr_q;
  assign write_to_onoff  = onoffData_q;
  assign write_to_player = playerData_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Scoreboard bench for board_mem_arbiter: a cycle-level reference model queues expected port
// values, a negedge monitor compares them; directed scenarios add targeted checks.
module tb_board_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_req;
  logic       clear_busy;
  logic       clear_done;
  logic       game_req;
  logic [2:0] game_addr;
  logic [5:0] game_onoff;
  logic [5:0] game_player;
  logic       game_gnt;
  logic       vga_req;
  logic [2:0] vga_addr;
  logic       vga_gnt;
  logic       vga_valid;
  logic [2:0] mem_address;
  logic       onoff_write;
  logic       player_write;
  logic [5:0] write_to_onoff;
  logic [5:0] write_to_player;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       gameGnt;
    logic       vgaGnt;
    logic       vgaValid;
    logic [2:0] addr;
    logic       onoffWr;
    logic       playerWr;
    logic [5:0] onoffData;
    logic [5:0] playerData;
  } expOut_t;

  expOut_t expQ[$];
  int      checks = 0;
  int      errors = 0;

`ifdef BOARD_ARB_AGE_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  board_mem_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .clear_req       (clear_req),
    .clear_busy      (clear_busy),
    .clear_done      (clear_done),
    .game_req        (game_req),
    .game_addr       (game_addr),
    .game_onoff      (game_onoff),
    .game_player     (game_player),
    .game_gnt        (game_gnt),
    .vga_req         (vga_req),
    .vga_addr        (vga_addr),
    .vga_gnt         (vga_gnt),
    .vga_valid       (vga_valid),
    .mem_address     (mem_address),
    .onoff_write     (onoff_write),
    .player_write    (player_write),
    .write_to_onoff  (write_to_onoff),
    .write_to_player (write_to_player)
  );

  always #5 clk = ~clk;

  // Reference model: clrStep -1 = idle, 0..6 = column being cleared, 7 = done cycle.
  int clrStep  = -1;
  bit lastGame = 1'b0;
  bit lastVga  = 1'b0;
  int vgaWait  = 0;

  always @(posedge clk) begin
    expOut_t e;
    bit mayGrant, gameWant, vgaWant, vgaUrgent, gameWin, vgaWin;
    e       = '0;
    gameWin = 1'b0;
    vgaWin  = 1'b0;
    if (reset) begin
      clrStep  = -1;
      lastGame = 1'b0;
      lastVga  = 1'b0;
      vgaWait  = 0;
    end else begin
      e.vgaValid = lastVga;
      mayGrant   = (clrStep == 7) || (clrStep == -1 && !clear_req);
      if (clrStep == -1) begin
        if (clear_req) clrStep = 0;
      end else if (clrStep == 7) begin
        clrStep = -1;
      end else begin
        clrStep++;
      end
      vgaUrgent = AGE_EN && (vgaWait >= 4);
      gameWant  = game_req && !lastGame;
      vgaWant   = vga_req && !lastVga && !lastGame;
      if (mayGrant) begin
        if (vgaWant && (vgaUrgent || !gameWant)) vgaWin = 1'b1;
        else if (gameWant) gameWin = 1'b1;
      end
      if (clrStep >= 0 && clrStep <= 6) begin
        e.busy     = 1'b1;
        e.addr     = clrStep[2:0];
        e.onoffWr  = 1'b1;
        e.playerWr = 1'b1;
      end else if (clrStep == 7) begin
        e.done = 1'b1;
      end else if (gameWin) begin
        e.gameGnt    = 1'b1;
        e.addr       = game_addr;
        e.onoffWr    = (game_addr != 3'd7);
        e.playerWr   = (game_addr != 3'd7);
        e.onoffData  = game_onoff;
        e.playerData = game_player;
      end else if (vgaWin) begin
        e.vgaGnt = 1'b1;
        e.addr   = vga_addr;
      end
      if (!vga_req || lastVga) vgaWait = 0;
      else if (vgaWait < 7) vgaWait++;
      lastGame = gameWin;
      lastVga  = vgaWin;
    end
    expQ.push_back(e);
  end

  function automatic expOut_t sampleOutputs();
    return {clear_busy, clear_done, game_gnt, vga_gnt, vga_valid, mem_address,
            onoff_write, player_write, write_to_onoff, write_to_player};
  endfunction

  task automatic checkOutput(input expOut_t e);
    expOut_t a;
    a = sampleOutputs();
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL cycleOutputs t=%0t got=%h expected=%h (busy,done,gameGnt,vgaGnt,vgaValid,addr,wrOnoff,wrPlayer,dOnoff,dPlayer)",
               $time, a, e);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic applyStimulus(input logic clr, input logic gReq, input logic [2:0] gAddr,
                               input logic [5:0] gOn, input logic [5:0] gPl,
                               input logic vReq, input logic [2:0] vAddr, input int cycles);
    clear_req   = clr;
    game_req    = gReq;
    game_addr   = gAddr;
    game_onoff  = gOn;
    game_player = gPl;
    vga_req     = vReq;
    vga_addr    = vAddr;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the number of edges until the grant shows up, or 0 if the budget ran out.
  task automatic waitGrant(input bit forGame, input int budget, output int cycles);
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if ((forGame && game_gnt) || (!forGame && vga_gnt)) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int busyCycles, donePulses, lat, gameAt, vgaAt, vgaSeen;
    reset = 1'b1;
    applyStimulus(0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 2);
    checkValue("resetOutputs", int'(sampleOutputs()), 0);
    reset = 1'b0;
    applyStimulus(0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 2);

    $display("[TB] clear sequence");
    applyStimulus(1, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 1);
    clear_req  = 1'b0;
    busyCycles = 0;
    donePulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (clear_busy) begin
        checkValue("clearAddr", int'(mem_address), busyCycles);
        checkValue("clearWrites", int'({onoff_write, player_write, write_to_onoff, write_to_player}), 14'h3000);
        busyCycles++;
      end
      if (clear_done) donePulses++;
      @(posedge clk);
      #1;
    end
    checkValue("clearBusyCycles", busyCycles, 7);
    checkValue("clearDonePulses", donePulses, 1);
    checkValue("idleAfterClear", int'(sampleOutputs()), 0);

    $display("[TB] single game write");
    applyStimulus(0, 1, 3'd3, 6'h01, 6'h01, 0, 3'd0, 0);
    waitGrant(1'b1, 10, lat);
    game_req = 1'b0;
    checkValue("gameLatency", lat, 1);
    checkValue("gameAddr", int'(mem_address), 3);
    checkValue("gameWrites", int'({onoff_write, player_write}), 3);
    checkValue("gameData", int'({write_to_onoff, write_to_player}), 12'h041);
    applyStimulus(0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 3);

    $display("[TB] game and vga together");
    applyStimulus(0, 1, 3'd1, 6'h2A, 6'h15, 1, 3'd6, 0);
    gameAt = 0;
    vgaAt  = 0;
    for (int i = 1; i <= 12 && vgaAt == 0; i++) begin
      @(posedge clk);
      #1;
      if (game_gnt && vga_gnt) checkValue("dualGrant", 1, 0);
      if (game_gnt) begin
        gameAt   = i;
        game_req = 1'b0;
      end
      if (vga_gnt) begin
        vgaAt   = i;
        vga_req = 1'b0;
      end
    end
    checkValue("gameFirst", gameAt, 1);
    checkValue("vgaAfterGap", vgaAt, 3);
    checkValue("vgaAddr", int'(mem_address), 6);
    @(posedge clk);
    #1;
    checkValue("vgaValid", int'({vga_valid, vga_gnt}), 2);
    applyStimulus(0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 3);

    $display("[TB] game write to column 7");
    applyStimulus(0, 1, 3'd7, 6'h3F, 6'h3F, 0, 3'd0, 0);
    waitGrant(1'b1, 10, lat);
    game_req = 1'b0;
    checkValue("badColLatency", lat, 1);
    checkValue("badColWrites", int'({onoff_write, player_write}), 0);
    checkValue("badColAddr", int'(mem_address), 7);
    applyStimulus(0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 3);

    $display("[TB] clear and game on the same edge");
    applyStimulus(1, 1, 3'd2, 6'h05, 6'h0A, 0, 3'd0, 0);
    waitGrant(1'b1, 20, lat);
    clear_req = 1'b0;
    game_req  = 1'b0;
    checkValue("gameAfterClear", lat, 9);
    applyStimulus(0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 3);

    $display("[TB] reset during clear");
    applyStimulus(1, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 1);
    clear_req = 1'b0;
    applyStimulus(0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 3);
    checkValue("fourthClearAddr", int'(mem_address), 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkValue("outputsAfterAbort", int'(sampleOutputs()), 0);
    donePulses = 0;
    busyCycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (clear_done) donePulses++;
      if (clear_busy) busyCycles++;
      @(posedge clk);
      #1;
    end
    checkValue("abortNoDone", donePulses, 0);
    checkValue("abortNoBusy", busyCycles, 0);

    $display("[TB] continuous game and vga");
    applyStimulus(0, 1, 3'd5, 6'h3F, 6'h00, 1, 3'd4, 0);
`ifdef BOARD_ARB_AGE_EN
    waitGrant(1'b0, 8, lat);
    checkValue("vgaAgedWithin6", int'(lat >= 1 && lat <= 6), 1);
    game_req = 1'b0;
    vga_req  = 1'b0;
`else
    vgaSeen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (vga_gnt) vgaSeen++;
    end
    checkValue("vgaStarved", vgaSeen, 0);
    game_req = 1'b0;
    waitGrant(1'b0, 10, lat);
    vga_req = 1'b0;
    checkValue("vgaAfterGameDrops", int'(lat != 0), 1);
`endif
    applyStimulus(0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 3);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 79) == 0);
      clear_req   = ($urandom_range(0, 24) == 0);
      game_req    = ($urandom_range(0, 2) != 0);
      game_addr   = 3'($urandom_range(0, 7));
      game_onoff  = 6'($urandom);
      game_player = 6'($urandom);
      vga_req     = ($urandom_range(0, 1) == 1);
      vga_addr    = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    applyStimulus(0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
